mem_2w1r_sched: RTL and testbench

- Scheduler in front of the two-write/one-read memory macro (mem_2w1r).
- Arbitrates NUM_REQ write requesters onto the memory's two write ports, up to two grants per cycle, round-robin fair.
- Forbids same-address dual writes.
- Sequences the single read port with 1-cycle response latency and same-cycle write-to-read forwarding, so requesters see deterministic memory contents.

---
 rtl/mem_2w1r_sched_pkg.sv | 21 ++
 rtl/mem_2w1r_sched_rr_find_first.sv | 33 +++
 rtl/mem_2w1r_sched.sv | 147 ++++++++++++++
 tb/tb_mem_2w1r_sched.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_2w1r_sched_pkg.sv
// Shared constants and helpers for the two-write/one-read memory scheduler.
package mem_sched_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 4;
  localparam int unsigned DATA_WIDTH_DEF = 1;
  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  // Ceiling log2, never less than 1 so index vectors always have a bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
    end
    return (r == 0) ? 1 : r;
  endfunction

  localparam int unsigned IDX_W_DEF = clog2(NUM_REQ_DEF);

endpackage

// File: rtl/mem_2w1r_sched_rr_find_first.sv
// Finds the first set bit of req_i & mask_i, scanning upward from start_i with wrap.
module rr_find_first
  import mem_sched_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic [N-1:0]  mask_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Priority scan from the start pointer; the first hit wins.
  always_comb begin
    int unsigned pos;
    logic        hit;
    hit     = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(start_i) + k;
      if (pos >= N) pos = pos - N;
      if (!hit && req_i[pos] && mask_i[pos]) begin
        hit   = 1'b1;
        idx_o = IW'(pos);
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/mem_2w1r_sched.sv
// Round-robin dual write-port arbiter and forwarding read sequencer for mem_2w1r.
module mem_2w1r_sched
  import mem_sched_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          rd_valid,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic                          rd_ready,
  output logic                          rd_resp_valid,
  output logic [DATA_WIDTH-1:0]         rd_resp_data,
  output logic                          we0,
  output logic [ADDR_WIDTH-1:0]         waddr0,
  output logic [DATA_WIDTH-1:0]         wdata0,
  output logic                          we1,
  output logic [ADDR_WIDTH-1:0]         waddr1,
  output logic [DATA_WIDTH-1:0]         wdata1,
  output logic [ADDR_WIDTH-1:0]         raddr,
  input  logic [DATA_WIDTH-1:0]         rdata,
  output logic [CNT_WIDTH-1:0]          conflict_cnt
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] addr_a [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_a [NUM_REQ];

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  rd_resp_valid_q, rd_resp_valid_d;
  logic                  fwd_valid_q, fwd_valid_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

  logic                  found0, found1;
  logic [IDX_W-1:0]      idx0, idx1;
  logic [NUM_REQ-1:0]    p1_mask_c;
  logic [NUM_REQ-1:0]    conf_vec_c;

  // Unflatten the requester buses.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unflat
    assign addr_a[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Port 0 takes the first valid requester from the round-robin pointer.
  rr_find_first #(.N(NUM_REQ), .IW(IDX_W)) u_port0 (
    .req_i   (req_valid),
    .start_i (rr_ptr_q),
    .mask_i  ({NUM_REQ{1'b1}}),
    .found_o (found0),
    .idx_o   (idx0)
  );

  // Port-1 eligibility: later in the scan than port 0 and not aliasing its address.
  always_comb begin
    int unsigned off0, offj;
    p1_mask_c  = '0;
    conf_vec_c = '0;
    off0 = (32'(idx0) + NUM_REQ - 32'(rr_ptr_q)) % NUM_REQ;
    offj = 0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      offj = (j + NUM_REQ - 32'(rr_ptr_q)) % NUM_REQ;
      if (offj > off0) begin
        if (addr_a[j] == addr_a[idx0]) conf_vec_c[j] = req_valid[j];
        else                           p1_mask_c[j]  = 1'b1;
      end
    end
  end

  rr_find_first #(.N(NUM_REQ), .IW(IDX_W)) u_port1 (
    .req_i   (req_valid),
    .start_i (rr_ptr_q),
    .mask_i  (p1_mask_c),
    .found_o (found1),
    .idx_o   (idx1)
  );

  // Write port drive and grants, masked while in reset.
  always_comb begin
    req_ready = '0;
    we0       = found0 & ~rst;
    we1       = found1 & ~rst;
    waddr0    = addr_a[idx0];
    wdata0    = data_a[idx0];
    waddr1    = addr_a[idx1];
    wdata1    = data_a[idx1];
    if (!rst) begin
      if (found0) req_ready[idx0] = 1'b1;
      if (found1) req_ready[idx1] = 1'b1;
    end
  end

  // Next-state: pointer past the last grant, saturating conflict count, read forwarding.
  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    rd_resp_valid_d = rd_valid & ~rst;
    fwd_valid_d     = 1'b0;
    fwd_data_d      = fwd_data_q;
    if (found1)      rr_ptr_d = (32'(idx1) == NUM_REQ - 1) ? '0 : IDX_W'(32'(idx1) + 1);
    else if (found0) rr_ptr_d = (32'(idx0) == NUM_REQ - 1) ? '0 : IDX_W'(32'(idx0) + 1);
    if (found0 && (|conf_vec_c) && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_WIDTH'(1);
    if (rd_valid && !rst) begin
      if (we0 && (waddr0 == rd_addr)) begin
        fwd_valid_d = 1'b1;
        fwd_data_d  = wdata0;
      end else if (we1 && (waddr1 == rd_addr)) begin
        fwd_valid_d = 1'b1;
        fwd_data_d  = wdata1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q        <= '0;
      cnt_q           <= '0;
      rd_resp_valid_q <= 1'b0;
      fwd_valid_q     <= 1'b0;
      fwd_data_q      <= '0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      rd_resp_valid_q <= rd_resp_valid_d;
      fwd_valid_q     <= fwd_valid_d;
      fwd_data_q      <= fwd_data_d;
    end
  end

  // Read side: pass-through address; a pending response dies if reset arrives.
  assign rd_ready      = ~rst;
  assign raddr         = rd_addr;
  assign rd_resp_valid = rd_resp_valid_q & ~rst;
  assign rd_resp_data  = fwd_valid_q ? fwd_data_q : rdata;
  assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_mem_2w1r_sched.sv
// Directed bench for mem_2w1r_sched with a behavioural 2W1R memory attached.
module tb_mem_2w1r_sched;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 1;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rd_valid;
  logic [AW-1:0]   rd_addr;
  logic            rd_ready;
  logic            rd_resp_valid;
  logic [DW-1:0]   rd_resp_data;
  logic            we0, we1;
  logic [AW-1:0]   waddr0, waddr1, raddr;
  logic [DW-1:0]   wdata0, wdata1, rdata;
  logic [CW-1:0]   conflict_cnt;

  logic [DW-1:0]   mem [2**AW];
  int              n_chk = 0;
  int              n_fail = 0;
  int              gcnt [NR];

  mem_2w1r_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Memory macro: registered read returns pre-write contents.
  always @(posedge clk) begin
    if (we0) mem[waddr0] <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
    rdata <= mem[raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  initial begin
    logic [NR-1:0] exp_g [4];
    exp_g[0] = 4'b0011; exp_g[1] = 4'b1100; exp_g[2] = 4'b0011; exp_g[3] = 4'b1100;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    for (int i = 0; i < NR; i++) gcnt[i] = 0;
    rdata = '0;
    rst = 1'b1; rd_valid = 1'b0; rd_addr = '0;
    req_valid = '0; req_addr = '0; req_data = '0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(12 + i), 1'b1);

    // 1: reset holds everything quiet
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_we0", 32'(we0), 0);
      chk("rst_we1", 32'(we1), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_rd_ready", 32'(rd_ready), 0);
      chk("rst_cnt", 32'(conflict_cnt), 0);
      chk("rst_resp", 32'(rd_resp_valid), 0);
    end
    rst = 1'b0;
    #1;
    chk("first_waddr0", 32'(waddr0), 12);
    chk("first_waddr1", 32'(waddr1), 13);
    chk("first_rd_ready", 32'(rd_ready), 1);

    // 2: fairness with all four requesting distinct addresses
    for (int c = 0; c < 4; c++) begin
      chk("fair_ready", 32'(req_ready), 32'(exp_g[c]));
      for (int i = 0; i < NR; i++) gcnt[i] += int'(req_ready[i]);
      tick();
    end
    for (int i = 0; i < NR; i++) chk("fair_count", 32'(gcnt[i]), 2);

    // 3: same-address conflict between requesters 0 and 1
    set_req(0, 1'b1, 4'd5, 1'b1);
    set_req(1, 1'b1, 4'd5, 1'b0);
    set_req(2, 1'b1, 4'd9, 1'b1);
    set_req(3, 1'b0, 4'd0, 1'b0);
    #1;
    chk("conf_ready1", 32'(req_ready), 32'b0101);
    chk("conf_waddr0", 32'(waddr0), 5);
    chk("conf_waddr1", 32'(waddr1), 9);
    chk("conf_we1", 32'(we1), 1);
    tick();
    chk("conf_cnt1", 32'(conflict_cnt), 1);
    chk("conf_mem5_a", 32'(mem[5]), 1);
    set_req(0, 1'b0, 4'd5, 1'b1);
    set_req(2, 1'b0, 4'd9, 1'b1);
    #1;
    chk("conf_ready2", 32'(req_ready), 32'b0010);
    chk("conf_we1_off", 32'(we1), 0);
    chk("conf_wdata0", 32'(wdata0), 0);
    tick();
    chk("conf_mem5_b", 32'(mem[5]), 0);
    chk("conf_cnt_hold", 32'(conflict_cnt), 1);
    set_req(1, 1'b0, 4'd5, 1'b0);

    // 4: same-cycle write/read forwarding
    set_req(3, 1'b1, 4'd7, 1'b1);
    rd_valid = 1'b1; rd_addr = 4'd7;
    #1;
    chk("fwd_ready", 32'(req_ready), 32'b1000);
    tick();
    set_req(3, 1'b0, 4'd7, 1'b1);
    rd_valid = 1'b0;
    #1;
    chk("fwd_resp_valid", 32'(rd_resp_valid), 1);
    chk("fwd_resp_data", 32'(rd_resp_data), 1);
    tick();
    chk("fwd_resp_done", 32'(rd_resp_valid), 0);

    // 5: back-to-back reads of addr 2 with a write in the second cycle
    rd_valid = 1'b1; rd_addr = 4'd2;
    tick();
    chk("b2b_v1", 32'(rd_resp_valid), 1);
    chk("b2b_d1_old", 32'(rd_resp_data), 0);
    set_req(0, 1'b1, 4'd2, 1'b1);
    #1;
    chk("b2b_wr_ready", 32'(req_ready), 32'b0001);
    tick();
    set_req(0, 1'b0, 4'd2, 1'b1);
    chk("b2b_d2_fwd", 32'(rd_resp_data), 1);
    tick();
    chk("b2b_d3_mem", 32'(rd_resp_data), 1);
    tick();
    rd_valid = 1'b0;
    chk("b2b_v4", 32'(rd_resp_valid), 1);
    chk("b2b_d4_mem", 32'(rd_resp_data), 1);
    tick();
    chk("b2b_idle", 32'(rd_resp_valid), 0);

    // 6: saturate the conflict counter
    set_req(0, 1'b1, 4'd3, 1'b0);
    set_req(1, 1'b1, 4'd3, 1'b1);
    for (int c = 0; c < 20; c++) begin
      chk("no_dual_same", 32'(we0 & we1 & (waddr0 == waddr1)), 0);
      tick();
      if (c == 0) chk("sat_first_inc", 32'(conflict_cnt), 2);
    end
    chk("sat_value", 32'(conflict_cnt), 15);
    set_req(0, 1'b0, 4'd3, 1'b0);
    set_req(1, 1'b0, 4'd3, 1'b1);

    // Reset arriving the cycle after a read accept kills the response
    rd_valid = 1'b1; rd_addr = 4'd4;
    tick();
    rd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstrd_resp", 32'(rd_resp_valid), 0);
    chk("rstrd_ready", 32'(rd_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstrd_resp_after", 32'(rd_resp_valid), 0);
    chk("rstrd_cnt", 32'(conflict_cnt), 0);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(12 + i), 1'b0);
    #1;
    chk("rstrd_ptr0", 32'(req_ready), 32'b0011);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
